// File: rtl/dmem_responder.sv
// dmem_responder: one-outstanding word memory behind valid/ready request and response channels.
// Optional feature macro DMEM_RANGE_CHECK_EN flags requests at or beyond DEPTH*4 bytes with rsp_err.
module dmem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             oob_q, oob_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      mem_q [DEPTH];

  logic             accept_s;
  logic             enter_resp_s;
  logic             req_oob_s;
  logic [IDX_W-1:0] req_idx_s;
  logic             rd_we_s;
  logic             rd_oob_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [31:0]      rd_word_s;
  logic             unused_s;

  assign req_idx_s = req_addr[2 +: IDX_W];
`ifdef DMEM_RANGE_CHECK_EN
  assign req_oob_s = (req_addr[ADDR_W-1:IDX_W+2] != {(ADDR_W-IDX_W-2){1'b0}});
  assign unused_s  = ^req_addr[1:0];
`else
  assign req_oob_s = 1'b0;
  assign unused_s  = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};
`endif

  // The rsp_ready -> req_ready path lets a new request ride on the cycle a response retires.
  assign req_ready = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign accept_s  = req_valid && req_ready;

  // Leaving WAIT uses the captured request; a zero-latency accept uses the live one.
  assign rd_we_s   = (state_q == WAIT) ? we_q  : req_we;
  assign rd_oob_s  = (state_q == WAIT) ? oob_q : req_oob_s;
  assign rd_idx_s  = (state_q == WAIT) ? idx_q : req_idx_s;
  assign rd_word_s = mem_q[rd_idx_s];

  // Next-state, request capture and response formation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    oob_d        = oob_q;
    idx_d        = idx_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if ((state_q == RESP) && !rsp_ready) begin
          state_d = RESP;
        end else if (accept_s) begin
          we_d  = req_we;
          oob_d = req_oob_s;
          idx_d = req_idx_s;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = rd_oob_s;
      rsp_rdata_d = (rd_we_s || rd_oob_s) ? 32'd0 : rd_word_s;
    end else if (state_d != RESP) begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'd0;
      rsp_err_d   = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      oob_q       <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      oob_q       <= oob_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Stores commit on the accept edge, lane by lane; the array is never reset.
  always_ff @(posedge clk) begin
    if (accept_s && req_we && !req_oob_s) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem_q[req_idx_s][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=1 and a LATENCY=0 instance checked every cycle against a
// transaction-level memory model, plus directed literal expectations.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  // Transaction-level model: one pending response per instance, due lat_c cycles after accept.
  int          lat_c [2] = '{1, 0};
  bit          busy  [2];
  int          rem   [2];
  logic [31:0] exp_data [2];
  logic        exp_err  [2];
  logic [31:0] mm [2][1024];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (LATENCY=%0d) got %h expected %h", name, lat_c[u], act, exp);
    end
  endtask

  task automatic model_check();
    bit ev, er, oob;
    int idx;
    for (int u = 0; u < 2; u++) begin
      if (rst) busy[u] = 1'b0;
      ev = busy[u] && (rem[u] == 0);
      er = !rst && (!busy[u] || (ev && rsp_ready[u]));
      chk("req_ready", u, req_ready[u], er);
      chk("rsp_valid", u, rsp_valid[u], ev);
      if (ev) begin
        chk("rsp_rdata", u, rsp_rdata[u], exp_data[u]);
        chk("rsp_err", u, rsp_err[u], exp_err[u]);
      end else if (rst) begin
        chk("rst_rdata", u, rsp_rdata[u], 32'd0);
        chk("rst_err", u, rsp_err[u], 1'b0);
      end
      if (!rst) begin
        if (busy[u] && rem[u] > 0) rem[u]--;
        else if (ev && rsp_ready[u]) busy[u] = 1'b0;
        if (req_valid[u] && er) begin
          idx = int'(req_addr[u][11:2]);
`ifdef DMEM_RANGE_CHECK_EN
          oob = (req_addr[u] >= 32'h0000_1000);
`else
          oob = 1'b0;
`endif
          if (req_we[u]) begin
            if (!oob)
              for (int i = 0; i < 4; i++)
                if (req_be[u][i]) mm[u][idx][8*i +: 8] = req_wdata[u][8*i +: 8];
            exp_data[u] = 32'd0;
          end else begin
            exp_data[u] = oob ? 32'd0 : mm[u][idx];
          end
          exp_err[u] = oob;
          busy[u]    = 1'b1;
          rem[u]     = lat_c[u];
        end
      end
    end
  endtask

  task automatic step_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic step_pos();
    @(posedge clk);
    #1;
  endtask

  // Ends at the negedge before the accepting edge.
  task automatic wait_accept(input int u);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 20) begin
      step_neg();
      ok = req_ready[u];
      if (!ok) step_pos();
      n++;
    end
    chk("accept_bound", u, ok, 1'b1);
  endtask

  // Ends at the negedge where rsp_valid is seen; n counts negedges since the accept.
  task automatic wait_rsp(input int u, output logic [31:0] rd, output logic er, output int n);
    bit ok = 1'b0;
    n = 0; rd = 32'd0; er = 1'b0;
    while (!ok && n < 20) begin
      step_neg();
      n++;
      ok = rsp_valid[u];
      if (ok) begin rd = rsp_rdata[u]; er = rsp_err[u]; end
      else step_pos();
    end
    chk("rsp_bound", u, ok, 1'b1);
  endtask

  task automatic xact(input int u, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr; req_wdata[u] = wd; req_be[u] = be;
    rsp_ready[u] = 1'b1;
    wait_accept(u);
    step_pos();
    req_valid[u] = 1'b0; req_we[u] = 1'($urandom_range(0, 1)); req_addr[u] = $urandom;
    req_wdata[u] = $urandom; req_be[u] = 4'($urandom_range(0, 15));
    wait_rsp(u, rd, er, lat);
    step_pos();
  endtask

  task automatic load_check(input int u, input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd; logic er; int lat;
    xact(u, 1'b0, addr, 32'd0, 4'h0, rd, er, lat);
    chk(name, u, rd, exp);
    chk({name, "_err"}, u, er, 1'b0);
    chk({name, "_lat"}, u, lat, lat_c[u] + 1);
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'h5A00_0000 + 32'(k) * 32'h0001_0203;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = 32'd0; req_wdata[u] = 32'd0;
      req_be[u] = 4'h0; rsp_ready[u] = 1'b1; busy[u] = 1'b0; rem[u] = 0;
    end
    step_neg();
    chk("reset_valid", 0, rsp_valid[0], 1'b0);
    chk("reset_rdata", 0, rsp_rdata[0], 32'd0);
    step_pos();
    rst = 1'b0;
    step_neg();
    chk("post_reset_ready", 0, req_ready[0], 1'b1);
    chk("post_reset_ready", 1, req_ready[1], 1'b1);
    step_pos();

    // Store/load and byte lanes on the LATENCY=1 instance.
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("store_rdata", 0, rd, 32'd0);
    chk("store_lat", 0, lat, 2);
    load_check(0, 32'h10, 32'hDEAD_BEEF, "load_full");
    xact(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, rd, er, lat);
    load_check(0, 32'h10, 32'hDEAD_BEAA, "load_lane0");
    xact(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    chk("be0_lat", 0, lat, 2);
    load_check(0, 32'h10, 32'hDEAD_BEAA, "load_be0");

    // Backpressure, then a request accepted on the retiring cycle.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; rsp_ready[0] = 1'b0;
    wait_accept(0);
    step_pos();
    req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'h1122_3344; req_be[0] = 4'hF;
    wait_rsp(0, rd, er, lat);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step_neg();
      chk("bp_valid", 0, rsp_valid[0], 1'b1);
      chk("bp_rdata", 0, rsp_rdata[0], 32'hDEAD_BEAA);
      chk("bp_ready", 0, req_ready[0], 1'b0);
      step_pos();
    end
    rsp_ready[0] = 1'b1;
    step_neg();
    chk("b2b_ready", 0, req_ready[0], 1'b1);
    step_pos();
    req_valid[0] = 1'b0;
    wait_rsp(0, rd, er, lat);
    step_pos();
    load_check(0, 32'h30, 32'h1122_3344, "b2b_load");

    // Address range / wrap.
    xact(0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, rd, er, lat);
    xact(0, 1'b0, 32'h1000, 32'd0, 4'h0, rd, er, lat);
`ifdef DMEM_RANGE_CHECK_EN
    chk("oob_load_err", 0, er, 1'b1);
    chk("oob_load_rdata", 0, rd, 32'd0);
`else
    chk("wrap_load_rdata", 0, rd, 32'h1234_5678);
`endif
    xact(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, rd, er, lat);
`ifdef DMEM_RANGE_CHECK_EN
    chk("oob_store_err", 0, er, 1'b1);
    load_check(0, 32'h0, 32'h1234_5678, "oob_word0");
`else
    load_check(0, 32'h0, 32'hCAFE_F00D, "wrap_word0");
`endif

    // Reset during the wait state of a load.
    xact(0, 1'b1, 32'h20, 32'hA5A5_5A5A, 4'hF, rd, er, lat);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h20;
    wait_accept(0);
    step_pos();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", 0, rsp_valid[0], 1'b0);
    step_neg();
    step_pos();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_neg();
      chk("rst_ready", 0, req_ready[0], 1'b1);
      step_pos();
    end
    load_check(0, 32'h20, 32'hA5A5_5A5A, "rst_load");

    // Streaming on the LATENCY=0 instance.
    for (int k = 0; k < 8; k++) xact(1, 1'b1, 32'(4 * k), pat(k), 4'hF, rd, er, lat);
    rsp_ready[1] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'(4 * k); end
      else req_valid[1] = 1'b0;
      step_neg();
      if (k < 8) chk("stream_ready", 1, req_ready[1], 1'b1);
      if (k > 0) begin
        chk("stream_valid", 1, rsp_valid[1], 1'b1);
        chk("stream_rdata", 1, rsp_rdata[1], pat(k - 1));
      end
      step_pos();
    end

    // Random traffic, including withdrawn requests and aliased/out-of-range addresses.
    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < 8; w++) xact(u, 1'b1, 32'h40 + 32'(4 * w), $urandom, 4'hF, rd, er, lat);
      for (int c = 0; c < 300; c++) begin
        req_valid[u] = 1'($urandom_range(0, 1));
        req_we[u]    = 1'($urandom_range(0, 1));
        req_addr[u]  = 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) req_addr[u] = req_addr[u] | (32'h1000 << $urandom_range(0, 3));
        req_wdata[u] = $urandom;
        req_be[u]    = 4'($urandom_range(0, 15));
        rsp_ready[u] = ($urandom_range(0, 3) != 0);
        step_neg();
        step_pos();
      end
      req_valid[u] = 1'b0;
      rsp_ready[u] = 1'b1;
      for (int c = 0; c < 20; c++) begin
        step_neg();
        step_pos();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
